filter_stream_manager: RTL and testbench

FILTER_STREAM_MANAGER -- requirements
Module: filter_stream_manager

---
 rtl/filter_stream_manager_if.sv | 42 ++++
 rtl/filter_stream_manager.sv | 162 ++++++++++++++++
 tb/tb_filter_stream_manager.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_stream_manager_if.sv
// Memory read bus and output stream handshake.
// master drives address/enable/beat; slave drives data/ack.
interface filter_stream_manager_if #(
  parameter int DATA_W      = 16,
  parameter int NUM_FILTERS = 4,
  parameter int ADDR_W      = 9,
  parameter int IDX_W       = 4
);
  logic [ADDR_W-1:0]             vector_memory_address;
  logic                          memory_enable;
  logic                          memory_write;
  logic [DATA_W-1:0]             vector_element;
  logic                          elements_ack;
  logic                          b_elements_ready;
  logic [NUM_FILTERS*DATA_W-1:0] b_elements;
  logic [IDX_W-1:0]              element_index;
  logic                          last_element;

  modport master (
    output vector_memory_address,
    output memory_enable,
    output memory_write,
    input  vector_element,
    output b_elements_ready,
    output b_elements,
    output element_index,
    output last_element,
    input  elements_ack
  );

  modport slave (
    input  vector_memory_address,
    input  memory_enable,
    input  memory_write,
    output vector_element,
    input  b_elements_ready,
    input  b_elements,
    input  element_index,
    input  last_element,
    output elements_ack
  );
endinterface

// File: rtl/filter_stream_manager.sv
// Caches NUM_FILTERS vectors from memory, then streams
// element e of every filter per beat, wrapping forever.
// Ports: i_clock, i_clear (sync active-high), i_en,
//   i_reload (only with FSM_RELOAD_EN), o_cached,
//   bus (master): memory read bus + output stream.
// Optional: `define FSM_RELOAD_EN adds reload in STREAM.
module filter_stream_manager #(
  parameter int DATA_W      = 16,
  parameter int ELEM_COUNT  = 16,
  parameter int NUM_FILTERS = 4,
  parameter int ADDR_W      = 9,
  parameter int BASE_ADDR   = 0
) (
  input  logic i_clock,
  input  logic i_clear,
  input  logic i_en,
`ifdef FSM_RELOAD_EN
  input  logic i_reload,
`endif
  output logic o_cached,
  filter_stream_manager_if.master bus
);

  localparam int EW = $clog2(ELEM_COUNT);
  localparam int FW =
    (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_STREAM
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [FW-1:0] r_f;
  logic [EW-1:0] r_e;
  logic          r_pend;
  logic [FW-1:0] r_pf;
  logic [EW-1:0] r_pe;
  logic          r_cached;

  logic [DATA_W-1:0] r_cache [NUM_FILTERS][ELEM_COUNT];

  logic w_issue;
  logic w_rdy;
  logic w_accept;
  logic w_reload;
  logic w_reload_go;
  logic w_to_stream;

  logic [NUM_FILTERS*DATA_W-1:0] w_beat;

`ifdef FSM_RELOAD_EN
  assign w_reload = i_reload;
`else
  assign w_reload = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_clear) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_issue     = 1'b0;
    w_rdy       = 1'b0;
    w_accept    = 1'b0;
    w_reload_go = 1'b0;
    w_to_stream = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_en) w_next = S_FILL;
      end
      S_FILL: begin
        if (i_en) begin
          w_issue = 1'b1;
          if (r_f == FW'(NUM_FILTERS - 1) &&
              r_e == '1)
            w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_en) begin
          w_next      = S_STREAM;
          w_to_stream = 1'b1;
        end
      end
      S_STREAM: begin
        w_rdy    = 1'b1;
        w_accept = bus.elements_ack & i_en;
        if (w_reload & i_en) begin
          w_reload_go = 1'b1;
          w_next      = S_FILL;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Read tag travels with the request so the returning
  // word lands in the slot it was fetched for.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_f      <= '0;
      r_e      <= '0;
      r_pend   <= 1'b0;
      r_pf     <= '0;
      r_pe     <= '0;
      r_cached <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_pf <= r_f;
        r_pe <= r_e;
      end
      if (w_issue) begin
        r_e <= r_e + 1'b1;
        if (r_e == '1)
          r_f <= (r_f == FW'(NUM_FILTERS - 1))
                 ? '0 : r_f + 1'b1;
      end else if (w_reload_go) begin
        r_f <= '0;
        r_e <= '0;
      end else if (w_accept) begin
        r_e <= r_e + 1'b1;
      end
      if (w_to_stream)      r_cached <= 1'b1;
      else if (w_reload_go) r_cached <= 1'b0;
    end
  end

  // Capture ignores en; a return coinciding with clear
  // is dropped.
  always_ff @(posedge i_clock) begin
    if (r_pend && !i_clear)
      r_cache[r_pf][r_pe] <= bus.vector_element;
  end

  for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_beat
    assign w_beat[g*DATA_W +: DATA_W] =
      w_rdy ? r_cache[g][r_e] : '0;
  end

  assign bus.memory_enable = w_issue;
  assign bus.memory_write  = 1'b0;
  assign bus.vector_memory_address =
    (r_state == S_FILL)
      ? ADDR_W'(BASE_ADDR) + ADDR_W'({r_f, r_e})
      : '0;

  assign bus.b_elements_ready = w_rdy;
  assign bus.b_elements       = w_beat;
  assign bus.element_index    = w_rdy ? r_e : '0;
  assign bus.last_element     = w_rdy & (r_e == '1);

  assign o_cached = r_cached;

endmodule

// File: tb/tb_filter_stream_manager.sv
// Directed bench for filter_stream_manager.
// Memory word at address a holds a + ofs.
module tb_filter_stream_manager;

`ifdef FSM_RELOAD_EN
  localparam int NF = 2;
  localparam int BA = 100;
`else
  localparam int NF = 4;
  localparam int BA = 0;
`endif
  localparam int EC = 16;
  localparam int N  = NF * EC;
  localparam int CLR_AT = (N > 44) ? 40 : N - 8;
  localparam int STL_AT = 20;

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic en = 1'b0;
  logic reload = 1'b0;
  logic cached;
  int   ofs = 0;
  int   tests = 0;
  int   fails = 0;

  filter_stream_manager_if #(
    .DATA_W(16), .NUM_FILTERS(NF),
    .ADDR_W(9), .IDX_W(4)
  ) bus ();

  filter_stream_manager #(
    .DATA_W(16), .ELEM_COUNT(EC),
    .NUM_FILTERS(NF), .ADDR_W(9),
    .BASE_ADDR(BA)
  ) dut (
    .i_clock(clk),
    .i_clear(clear),
    .i_en(en),
`ifdef FSM_RELOAD_EN
    .i_reload(reload),
`endif
    .o_cached(cached),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.memory_enable)
      bus.vector_element <=
        16'(int'(bus.vector_memory_address) + ofs);

  function automatic logic [NF*16-1:0] exp_beat(int e);
    logic [NF*16-1:0] r;
    r = '0;
    for (int f = 0; f < NF; f++)
      r[f*16 +: 16] = 16'(BA + f*EC + e + ofs);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    en = 1'b0;
    bus.elements_ack = 1'b0;
    bus.vector_element = '0;
    step();
    step();
    tests++;
    if (bus.b_elements_ready !== 1'b0 ||
        bus.memory_enable !== 1'b0 ||
        bus.memory_write !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl got rdy=%b me=%b mw=%b want 0",
        bus.b_elements_ready, bus.memory_enable,
        bus.memory_write);
    end
    tests++;
    if (bus.b_elements !== '0 || cached !== 1'b0 ||
        bus.element_index !== 4'd0 ||
        bus.last_element !== 1'b0) begin
      fails++;
      $display("FAIL reset_out got b=%h c=%b i=%0d l=%b want 0",
        bus.b_elements, cached, bus.element_index,
        bus.last_element);
    end
    clear = 1'b0;
  endtask

  // Runs a fill from the current state until the first
  // valid beat; issued/cyc are carried in for restarts.
  task automatic run_fill(input int issued0,
                          input int cyc0,
                          input string nm);
    int issued = issued0;
    int cyc = cyc0;
    while (bus.b_elements_ready !== 1'b1 && cyc < 300) begin
      step();
      cyc++;
      if (bus.memory_enable === 1'b1) begin
        tests++;
        if (bus.vector_memory_address !== 9'(BA + issued)) begin
          fails++;
          $display("FAIL %s_addr got %0d want %0d", nm,
            bus.vector_memory_address, BA + issued);
        end
        issued++;
      end
    end
    tests++;
    if (cyc != N + 2 || issued != N) begin
      fails++;
      $display("FAIL %s_latency got cyc=%0d rd=%0d want %0d %0d",
        nm, cyc, issued, N + 2, N);
    end
  endtask

  task automatic test_fill();
    bus.elements_ack = 1'b1;
    en = 1'b1;
    run_fill(0, 0, "fill");
    tests++;
    if (bus.b_elements !== exp_beat(0) || cached !== 1'b1 ||
        bus.element_index !== 4'd0) begin
      fails++;
      $display("FAIL beat0 got %h c=%b i=%0d want %h",
        bus.b_elements, cached, bus.element_index,
        exp_beat(0));
    end
    step();
    tests++;
    if (bus.b_elements !== exp_beat(1) ||
        bus.element_index !== 4'd1 ||
        bus.memory_enable !== 1'b0) begin
      fails++;
      $display("FAIL beat1 got %h i=%0d me=%b want %h",
        bus.b_elements, bus.element_index,
        bus.memory_enable, exp_beat(1));
    end
  endtask

  task automatic test_stall();
    step();
    step();
    bus.elements_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (bus.b_elements !== exp_beat(3) ||
          bus.element_index !== 4'd3 ||
          bus.b_elements_ready !== 1'b1) begin
        fails++;
        $display("FAIL stall%0d got %h i=%0d want %h",
          k, bus.b_elements, bus.element_index,
          exp_beat(3));
      end
      step();
    end
    bus.elements_ack = 1'b1;
    for (int k = 3; k < 6; k++) begin
      tests++;
      if (bus.b_elements !== exp_beat(k) ||
          bus.element_index !== 4'(k)) begin
        fails++;
        $display("FAIL adv%0d got %h i=%0d want %h",
          k, bus.b_elements, bus.element_index,
          exp_beat(k));
      end
      step();
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    while (bus.element_index !== 4'd15 && n < 40) begin
      step();
      n++;
    end
    tests++;
    if (bus.last_element !== 1'b1 ||
        bus.b_elements !== exp_beat(15)) begin
      fails++;
      $display("FAIL last got l=%b b=%h want 1 %h",
        bus.last_element, bus.b_elements, exp_beat(15));
    end
    step();
    tests++;
    if (bus.element_index !== 4'd0 ||
        bus.last_element !== 1'b0 ||
        bus.b_elements !== exp_beat(0) ||
        bus.memory_enable !== 1'b0) begin
      fails++;
      $display("FAIL wrap got i=%0d l=%b b=%h me=%b want 0 0 %h 0",
        bus.element_index, bus.last_element,
        bus.b_elements, bus.memory_enable, exp_beat(0));
    end
  endtask

  task automatic test_clear_refill();
    int n;
    int issued;
    clear = 1'b1;
    step();
    clear = 1'b0;
    n = 0;
    while (!(bus.memory_enable === 1'b1 &&
             bus.vector_memory_address === 9'(BA + CLR_AT)) &&
           n < 300) begin
      step();
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL clr_reach got timeout want addr %0d",
        BA + CLR_AT);
    end
    clear = 1'b1;
    step();
    tests++;
    if (bus.memory_enable !== 1'b0 ||
        bus.b_elements_ready !== 1'b0 ||
        bus.vector_memory_address !== '0 ||
        bus.b_elements !== '0 || cached !== 1'b0) begin
      fails++;
      $display("FAIL clr_out got me=%b rdy=%b a=%0d c=%b want 0",
        bus.memory_enable, bus.b_elements_ready,
        bus.vector_memory_address, cached);
    end
    clear = 1'b0;
    step();
    tests++;
    if (bus.memory_enable !== 1'b1 ||
        bus.vector_memory_address !== 9'(BA)) begin
      fails++;
      $display("FAIL clr_restart got me=%b a=%0d want 1 %0d",
        bus.memory_enable, bus.vector_memory_address, BA);
    end
    issued = 1;
    while (bus.vector_memory_address !== 9'(BA + STL_AT) &&
           issued < N) begin
      step();
      issued++;
    end
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if (bus.memory_enable !== 1'b0 ||
          bus.vector_memory_address !== 9'(BA + STL_AT)) begin
        fails++;
        $display("FAIL en_hold%0d got me=%b a=%0d want 0 %0d",
          k, bus.memory_enable,
          bus.vector_memory_address, BA + STL_AT);
      end
      if (k < 3) step();
    end
    en = 1'b1;
    #1;
    tests++;
    if (bus.memory_enable !== 1'b1 ||
        bus.vector_memory_address !== 9'(BA + STL_AT)) begin
      fails++;
      $display("FAIL en_resume got me=%b a=%0d want 1 %0d",
        bus.memory_enable, bus.vector_memory_address,
        BA + STL_AT);
    end
    n = 0;
    while (bus.b_elements_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    for (int e = 0; e < EC; e++) begin
      tests++;
      if (bus.b_elements !== exp_beat(e) ||
          bus.element_index !== 4'(e)) begin
        fails++;
        $display("FAIL refill_e%0d got %h i=%0d want %h",
          e, bus.b_elements, bus.element_index,
          exp_beat(e));
      end
      step();
    end
  endtask

`ifdef FSM_RELOAD_EN
  task automatic test_reload();
    step();
    ofs = 1000;
    reload = 1'b1;
    step();
    reload = 1'b0;
    tests++;
    if (bus.b_elements_ready !== 1'b0 || cached !== 1'b0 ||
        bus.memory_enable !== 1'b1 ||
        bus.vector_memory_address !== 9'(BA)) begin
      fails++;
      $display("FAIL reload_go got rdy=%b c=%b me=%b a=%0d",
        bus.b_elements_ready, cached, bus.memory_enable,
        bus.vector_memory_address);
    end
    run_fill(1, 1, "reload");
    for (int e = 0; e < 2; e++) begin
      tests++;
      if (bus.b_elements !== exp_beat(e)) begin
        fails++;
        $display("FAIL reload_e%0d got %h want %h",
          e, bus.b_elements, exp_beat(e));
      end
      step();
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_fill();
    test_stall();
    test_wrap();
    test_clear_refill();
`ifdef FSM_RELOAD_EN
    test_reload();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
